// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: forwarding-mux select codes
// and the stall FSM state encoding.
// Imported by hazard_ctrl_unit and hazard_stall_fsm.
package hazard_pkg;

  // EX operand mux selects
  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from the MEM/WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from the EX/MEM result

  // Stall FSM states
  typedef enum logic {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_stall_fsm.sv
// Load-use stall sequencer: turns a load-use hit into LOAD_STALL bubble cycles.
// Latency: stall is combinational in the detecting cycle; later stall cycles come from state.
// Backpressure: branch_taken aborts any pending stall; stall_cnt saturates at all-ones.
module hazard_stall_fsm
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             luh,
  input  logic             branch_taken,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;

  // State and remaining-stall counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and stall decision; a taken branch overrides everything
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    if (branch_taken) begin
      state_nxt = S_RUN;
      cnt_nxt   = 2'd0;
    end else begin
      case (state)
        S_RUN: begin
          if (luh) begin
            // The detecting cycle is already the first bubble
            stall = 1'b1;
            if (LOAD_STALL > 1) begin
              state_nxt = S_STALL;
              cnt_nxt   = 2'(LOAD_STALL - 1);
            end
          end
        end
        S_STALL: begin
          stall = 1'b1;
          if (cnt == 2'd1) begin
            state_nxt = S_RUN;
            cnt_nxt   = 2'd0;
          end else begin
            cnt_nxt = cnt - 2'd1;
          end
        end
        default: begin
          state_nxt = S_RUN;
          cnt_nxt   = 2'd0;
        end
      endcase
    end
    // Keep the pipeline running while reset is held, whatever the inputs show
    if (reset) begin
      stall = 1'b0;
    end
  end

  // Saturating count of stall cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard detection and forwarding control for the 5-stage core, beside ID.
// Latency: stall/flush outputs combinational; forwarding selects registered (valid when consumer is in EX).
// Backpressure: load-use holds PC and IF/ID and bubbles ID/EX; taken branch flushes IF/ID and ID/EX.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW             = 5,
  parameter int LOAD_STALL         = 1,
  parameter int ZERO_REG_HARDWIRED = 1,
  parameter int CNT_W              = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic              branch_taken,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [REG_AW-1:0] mem_rd;
  logic              mem_we;
  logic              rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
  logic              luh, stall;
  logic [1:0]        fwd_a_nxt, fwd_b_nxt;

  // Tag equality, ignoring the hardwired zero register when enabled
  function automatic logic tag_match(input logic [REG_AW-1:0] x, input logic [REG_AW-1:0] y);
    return (x == y) && !((ZERO_REG_HARDWIRED != 0) && (y == '0));
  endfunction

  // Tag compares against the EX producer and the MEM shadow
  always_comb begin
    rs_ex_hit  = id_rs_used && tag_match(id_rs, ex_rd);
    rt_ex_hit  = id_rt_used && tag_match(id_rt, ex_rd);
    rs_mem_hit = id_rs_used && mem_we && tag_match(id_rs, mem_rd);
    rt_mem_hit = id_rt_used && mem_we && tag_match(id_rt, mem_rd);
    luh        = ex_is_load && ex_wr_en && (rs_ex_hit || rt_ex_hit);
  end

  hazard_stall_fsm #(
    .LOAD_STALL (LOAD_STALL),
    .CNT_W      (CNT_W)
  ) u_stall_fsm (
    .clk          (clk),
    .reset        (reset),
    .luh          (luh),
    .branch_taken (branch_taken),
    .stall        (stall),
    .stall_cnt    (stall_cnt)
  );

  // Pipeline enables and flushes; gated by reset so outputs show reset values at once
  always_comb begin
    pc_we      = !stall;
    ifid_we    = !stall;
    idex_flush = !reset && (stall || branch_taken);
    ifid_flush = !reset && branch_taken;
  end

  // Forwarding select for the instruction about to enter EX; EX producer wins over MEM.
  // Loads are excluded from EX forwarding: their data only exists after MEM.
  always_comb begin
    fwd_a_nxt = FWD_RF;
    fwd_b_nxt = FWD_RF;
    if (rs_ex_hit && ex_wr_en && !ex_is_load) begin
      fwd_a_nxt = FWD_MEM;
    end else if (rs_mem_hit) begin
      fwd_a_nxt = FWD_WB;
    end
    if (rt_ex_hit && ex_wr_en && !ex_is_load) begin
      fwd_b_nxt = FWD_MEM;
    end else if (rt_mem_hit) begin
      fwd_b_nxt = FWD_WB;
    end
  end

  // MEM-stage shadow of the EX destination, refreshed every cycle (bubbles carry wr_en=0)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rd <= '0;
      mem_we <= 1'b0;
    end else begin
      mem_rd <= ex_rd;
      mem_we <= ex_wr_en;
    end
  end

  // Registered selects; a bubble enters EX on stall or branch flush, so no forwarding then
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else if (stall || branch_taken) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else begin
      fwd_a <= fwd_a_nxt;
      fwd_b <= fwd_b_nxt;
    end
  end

endmodule
